mips_multicycle_control: RTL

- Main control state machine for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over one shared ALU and one shared memory port.
- Drives the 3-bit ALUOp consumed by alu_control_unit, plus all datapath mux selects and write enables.
- Stalls on a single memory-ready handshake.

---
 rtl/mips_multicycle_control.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// Main control FSM for the multi-cycle MIPS datapath. It sequences
// fetch / decode / execute / memory / writeback over one shared ALU and
// one shared memory port. The only stall source is the mem_ready handshake.
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset (aborts any instruction)
//   opcode[5:0]  instr[31:26], sampled and latched in DECODE
//   mem_ready    memory completes the current access this cycle
//   pc_write     unconditional PC load (gated by mem_ready in FETCH)
//   pc_write_beq PC load if ALU zero=1
//   pc_write_bne PC load if ALU zero=0
//   iord         memory address select: 0=PC, 1=ALUOut
//   mem_read     memory read strobe
//   mem_write    memory write strobe
//   ir_write     instruction register load (gated by mem_ready in FETCH)
//   mem_to_reg   register write data: 1=MDR, 0=ALUOut
//   reg_dst      destination register: 1=rd, 0=rt
//   reg_write    register file write enable
//   alu_src_a    ALU A: 0=PC, 1=regA
//   alu_src_b    ALU B: 00=regB, 01=4, 10=ext imm, 11=imm<<2
//   pc_source    PC source: 00=ALU result, 01=ALUOut, 10=jump target
//   alu_op[2:0]  ALUOp to alu_control_unit
//   illegal_op   one-cycle pulse in DECODE for an unsupported opcode
//   state_o[3:0] state encoding for debug:
//                0 IDLE, 1 FETCH, 2 DECODE, 3 MEMADR, 4 MEMRD, 5 MEMWB,
//                6 MEMWR, 7 EXEC, 8 ALUWB, 9 IEXEC, 10 IWB, 11 BRANCH, 12 JUMP

module mips_multicycle_control #(
  parameter int RESET_VECTOR_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_beq,
  output logic       pc_write_bne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    BRANCH = 4'd11,
    JUMP   = 4'd12
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(RESET_VECTOR_HOLD - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t     state;
  logic [3:0] hold_cnt;
  logic [5:0] op_q;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_SLTI)  || (op == OP_SLTIU) ||
           (op == OP_LUI);
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] r;
    case (op)
      OP_ANDI:           r = 3'b100;
      OP_ORI:            r = 3'b101;
      OP_SLTI, OP_SLTIU: r = 3'b110;
      default:           r = 3'b000;
    endcase
    return r;
  endfunction

  // The opcode is captured on the DECODE cycle so later states (load vs
  // store, immediate ALU op, beq vs bne) never depend on the live IR bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= 4'd0;
      op_q     <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hold_cnt >= HOLD_LAST) begin
            state    <= FETCH;
            hold_cnt <= 4'd0;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        FETCH: begin
          if (mem_ready) state <= DECODE;
        end
        DECODE: begin
          op_q <= opcode;
          if (opcode == OP_RTYPE)                     state <= EXEC;
          else if (is_load(opcode) || is_store(opcode)) state <= MEMADR;
          else if (opcode == OP_BEQ || opcode == OP_BNE) state <= BRANCH;
          else if (opcode == OP_J)                    state <= JUMP;
          else if (is_imm_alu(opcode))                state <= IEXEC;
          else                                        state <= FETCH;
        end
        MEMADR: state <= is_store(op_q) ? MEMWR : MEMRD;
        MEMRD:  if (mem_ready) state <= MEMWB;
        MEMWB:  state <= FETCH;
        MEMWR:  if (mem_ready) state <= FETCH;
        EXEC:   state <= ALUWB;
        ALUWB:  state <= FETCH;
        IEXEC:  state <= IWB;
        IWB:    state <= FETCH;
        BRANCH: state <= FETCH;
        JUMP:   state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs decode straight from the state register; FETCH additionally
  // gates the PC/IR loads with mem_ready so a stalled fetch is harmless.
  always_comb begin
    pc_write     = 1'b0;
    pc_write_beq = 1'b0;
    pc_write_bne = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    pc_source    = 2'b00;
    alu_op       = 3'b000;
    illegal_op   = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !((opcode == OP_RTYPE) || is_load(opcode) ||
                       is_store(opcode) || (opcode == OP_BEQ) ||
                       (opcode == OP_BNE) || (opcode == OP_J) ||
                       is_imm_alu(opcode));
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_alu_op(op_q);
      end
      IWB: begin
        reg_write = 1'b1;
        alu_op    = imm_alu_op(op_q);
      end
      BRANCH: begin
        alu_src_a    = 1'b1;
        alu_op       = 3'b001;
        pc_source    = 2'b01;
        pc_write_beq = (op_q == OP_BEQ);
        pc_write_bne = (op_q == OP_BNE);
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule
